vga_text_pixel_gen: RTL and testbench
=====================================

// Module: vga_text_pixel_gen
// PURPOSE
//  Pixel generator placed directly downstream of vga_sync. Renders an 80x30 grid of 8x16 glyphs
//  (clock digits/symbols) from a host-writable tile RAM. Drives rgb, plus hsync/vsync delayed so
//  all three stay aligned at the VGA connector.
// PARAMETERS
//  FG_COLOR      3'b010  rgb for glyph pixels "on"
//  BG_COLOR      3'b000  rgb for glyph pixels "off" inside video_on
//  BLINK_FRAMES  30      frames per cursor toggle (CURSOR_BLINK_EN only)
// PORTS
//  clk       in   1   system clock; same clock as vga_sync
//  reset     in   1   synchronous, active-high
//  p_tick    in   1   pixel enable from vga_sync; all pipeline stages advance only when high
//  video_on  in   1   from vga_sync
//  hsync_in  in   1   from vga_sync
//  vsync_in  in   1   from vga_sync
//  pixel_x   in   10  from vga_sync
//  pixel_y   in   10  from vga_sync
//  wr_en     in   1   host tile write strobe, one clk cycle
//  wr_col    in   7   target column, 0..79
//  wr_row    in   5   target row, 0..29
//  wr_code   in   4   glyph code
//  busy      out  1   high while the tile RAM is being cleared
//  hsync     out  1   hsync_in delayed 2 p_ticks
//  vsync     out  1   vsync_in delayed 2 p_ticks
//  rgb       out  3   pixel colour
// BEHAVIOUR
//  Reset: rgb=0, hsync=0, vsync=0, busy=1, pipeline regs=0, FSM->CLEAR, clear counter=0.
//  FSM CLEAR: writes code 15 (blank) to addr=counter on every clk. After addr 4095 -> RUN, busy=0
//   on the next clk. Total 4096 clks. While CLEAR: wr_en ignored; rgb=0; sync pipeline still runs.
//  FSM RUN: stays in RUN until reset. Reset asserted mid-clear restarts the clear at addr 0.
//  Tile RAM: 4096x4, addr={row[4:0],col[6:0]}. No multiplier. Entries with col>=80 unused.
//  Host write, RUN only: accepted when wr_en=1, wr_col<80, wr_row<30. Otherwise dropped silently.
//   Writes do not depend on p_tick.
//  Pipeline, advances on p_tick only:
//   S1: reads tile RAM (synchronous) at {pixel_y[8:4],pixel_x[9:3]}. Registers gy=pixel_y[3:0],
//       gx=pixel_x[2:0], video_on, hsync_in, vsync_in.
//   S2: font ROM (code,gy) -> 8-bit row; bit[7-gx] selected. MSB is the leftmost pixel.
//       rgb <= !video_on_d ? 0 : bit ? FG_COLOR : BG_COLOR. hsync/vsync <= S1 copies.
//  Latency: exactly 2 p_ticks from input pixel to rgb/hsync/vsync. All outputs hold between p_ticks.
//  Read/write collision on the same addr in the same clk: read returns the old code.
//  Glyph codes: 0-9 digits, 10 ':', 11 'A', 12 'P', 13 'M', 14 '-', 15 blank.
//   Code 15: all rows 8'h00. Code 14: rows 7,8 = 8'hFF, all other rows 8'h00.
// CONFIGURATION
//  CURSOR_BLINK_EN defined:
//   - cursor cell = last accepted write (reset -> col 0, row 0);
//   - frame counter increments on each rising edge of vsync_in sampled at p_tick;
//   - cursor_on toggles every BLINK_FRAMES frames; reset -> cursor_on=0;
//   - in S2, when cursor_on, the pixel is in the cursor cell and gy in {14,15}: rgb=FG_COLOR
//     (only when video_on).
//  CURSOR_BLINK_EN undefined: no cursor state, no frame counter; rgb is purely the glyph result.
// STRUCTURE
//  vga_text_pkg.vh (`include): GRID_COLS=80, GRID_ROWS=30, GLYPH_W=8, GLYPH_H=16,
//   glyph code localparams (CODE_COLON=10 .. CODE_BLANK=15), FSM state encodings.
//  Sub-module font_rom_digits: combinational case ROM, in code[3:0]+row[3:0], out 8-bit row.
//  Tile RAM inferred inline as block RAM.
// TESTING
//  1 Reset 1 clk, then run: busy=1 for 4096 clks, then 0. During clear, wr_en with code 14 at
//    (0,0) -> after clear, cell (0,0) renders blank.
//  2 After clear, write code 14 at (col 2,row 1). Scan pixel (x=16..23, y=23): rgb=3'b010.
//    Pixel (x=16, y=22): rgb=3'b000.
//  3 Latency: step hsync_in 0->1 at one p_tick -> hsync rises exactly 2 p_ticks later. rgb is
//    aligned with hsync. With p_tick held low, outputs hold.
//  4 video_on=0 at a pixel whose cell holds code 14, row 7 -> rgb=0.
//  5 Write with col=80 or row=30 -> no RAM change; read of (79,29) is unaffected.
//    Write colliding with a read of the same cell -> old code shown that pixel, new code next frame.
//  6 CURSOR_BLINK_EN: write at (5,3), drive 30 vsync pulses -> cursor rows y=62,63 at
//    x=40..47 show FG; after 30 more pulses -> BG.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared constants for the VGA text pixel generator: grid and glyph geometry,
// glyph codes, tile RAM addressing and the clear/run FSM encoding.
package vga_text_pkg;

    localparam int GRID_COLS = 80;
    localparam int GRID_ROWS = 30;
    localparam int GLYPH_W   = 8;
    localparam int GLYPH_H   = 16;

    // Tile RAM address is {row[4:0], col[6:0]}: power-of-two rows avoid a multiplier.
    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;
    localparam int ADDR_W = COL_W + ROW_W;
    localparam int CODE_W = 4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    // Glyph codes 0-9 are the decimal digits themselves.
    localparam logic [CODE_W-1:0] CODE_COLON = 4'd10;
    localparam logic [CODE_W-1:0] CODE_A     = 4'd11;
    localparam logic [CODE_W-1:0] CODE_P     = 4'd12;
    localparam logic [CODE_W-1:0] CODE_M     = 4'd13;
    localparam logic [CODE_W-1:0] CODE_DASH  = 4'd14;
    localparam logic [CODE_W-1:0] CODE_BLANK = 4'd15;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/vga_text_pixel_gen_font_rom_digits.sv
// Font ROM for the clock glyph set: 8x16 cells, row 0 at the top, bit 7 is the
// leftmost pixel. Purely combinational so it sits inside pipeline stage 2.
module font_rom_digits
    import vga_text_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic [3:0]        row,
    output logic [7:0]        bits
);

    logic [127:0] glyph;

    // Select the 16-row bitmap for the code, then pick the requested row (row 0 = MSB byte).
    always_comb begin
        glyph = '0;
        case (code)
            4'd0:       glyph = 128'h0000_7CC6_C6CE_DEF6_E6C6_C67C_0000_0000;
            4'd1:       glyph = 128'h0000_1838_7818_1818_1818_187E_0000_0000;
            4'd2:       glyph = 128'h0000_7CC6_060C_1830_60C0_C6FE_0000_0000;
            4'd3:       glyph = 128'h0000_7CC6_0606_3C06_0606_C67C_0000_0000;
            4'd4:       glyph = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C1E_0000_0000;
            4'd5:       glyph = 128'h0000_FEC0_C0C0_FC06_0606_C67C_0000_0000;
            4'd6:       glyph = 128'h0000_3860_C0C0_FCC6_C6C6_C67C_0000_0000;
            4'd7:       glyph = 128'h0000_FEC6_0606_0C18_3030_3030_0000_0000;
            4'd8:       glyph = 128'h0000_7CC6_C6C6_7CC6_C6C6_C67C_0000_0000;
            4'd9:       glyph = 128'h0000_7CC6_C6C6_7E06_0606_0C78_0000_0000;
            CODE_COLON: glyph = 128'h0000_0000_1818_0000_0018_1800_0000_0000;
            CODE_A:     glyph = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
            CODE_P:     glyph = 128'h0000_FC66_6666_7C60_6060_60F0_0000_0000;
            CODE_M:     glyph = 128'h0000_C6EE_FEFE_D6C6_C6C6_C6C6_0000_0000;
            CODE_DASH:  glyph = 128'h0000_0000_0000_00FF_FF00_0000_0000_0000;
            default:    glyph = '0;
        endcase
        bits = glyph[{4'd15 - row, 3'b000} +: 8];
    end

endmodule

// File: rtl/vga_text_pixel_gen.sv
// Text-mode pixel generator sitting directly behind vga_sync. Renders an 80x30
// grid of 8x16 glyphs from a host-writable 4096x4 tile RAM through a two-stage
// pipeline advanced by p_tick; hsync/vsync travel through the same two stages so
// rgb and sync stay aligned. After reset the tile RAM is cleared to blank (busy=1).
// Optional build macro: CURSOR_BLINK_EN adds a blinking underline cursor on the
// cell of the last accepted host write.
module vga_text_pixel_gen
    import vga_text_pkg::*;
#(
    parameter logic [2:0] FG_COLOR     = 3'b010,
    parameter logic [2:0] BG_COLOR     = 3'b000,
    parameter int         BLINK_FRAMES = 30
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              p_tick,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              wr_en,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [CODE_W-1:0] wr_code,
    output logic              busy,
    output logic              hsync,
    output logic              vsync,
    output logic [2:0]        rgb
);

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;

    logic [CODE_W-1:0]   tile_ram [0:(1 << ADDR_W)-1];
    logic                host_wr_ok;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [CODE_W-1:0]   ram_wdata;
    logic [ADDR_W-1:0]   rd_addr;

    logic [CODE_W-1:0]   s1_code;
    logic [3:0]          s1_gy;
    logic [2:0]          s1_gx;
    logic                s1_video_on;
    logic                s1_hsync;
    logic                s1_vsync;

    logic [7:0]          font_row;
    logic                glyph_bit;
    logic                cursor_pix;

    // Rows only reach 29, so pixel_y[9] never selects a cell.
    logic                unused_pixel_y9;
    assign unused_pixel_y9 = pixel_y[9];

    assign host_wr_ok = (state == ST_RUN) && wr_en
                        && (wr_col < COL_W'(GRID_COLS))
                        && (wr_row < ROW_W'(GRID_ROWS));

    assign rd_addr = {pixel_y[8:4], pixel_x[9:3]};

    // Tile RAM write port: the clear FSM owns it while busy, the host afterwards.
    always_comb begin
        // NOTE: always_comb uses blocking '=' with a default for every output first,
        // so no path leaves a signal unassigned and no latch is inferred.
        ram_we    = 1'b0;
        ram_waddr = {wr_row, wr_col};
        ram_wdata = wr_code;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt;
            ram_wdata = CODE_BLANK;
        end else begin
            ram_we    = host_wr_ok;
        end
    end

    // Clear/run FSM: sweep every RAM address once with blank, then run until reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register samples
        // the pre-edge values, independent of statement order.
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_ADDR) begin
                state <= ST_RUN;
                busy  <= 1'b0;
            end
        end
    end

    // Tile RAM write; independent of p_tick.
    always_ff @(posedge clk) begin
        // NOTE: the RAM array has no reset so it maps onto block RAM; the clear FSM
        // gives it a defined content instead.
        if (ram_we) begin
            tile_ram[ram_waddr] <= ram_wdata;
        end
    end

    // Stage 1 RAM read: same-address write in this clk returns the old code.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_code <= '0;
        end else if (p_tick) begin
            s1_code <= tile_ram[rd_addr];
        end
    end

    // Stage 1 side-band: glyph coordinates and sync/video flags travel with the code.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_gy       <= '0;
            s1_gx       <= '0;
            s1_video_on <= 1'b0;
            s1_hsync    <= 1'b0;
            s1_vsync    <= 1'b0;
        end else if (p_tick) begin
            s1_gy       <= pixel_y[3:0];
            s1_gx       <= pixel_x[2:0];
            s1_video_on <= video_on;
            s1_hsync    <= hsync_in;
            s1_vsync    <= vsync_in;
        end
    end

    font_rom_digits u_font (
        .code (s1_code),
        .row  (s1_gy),
        .bits (font_row)
    );

    assign glyph_bit = font_row[3'd7 - s1_gx];

`ifdef CURSOR_BLINK_EN
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);

    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             vsync_prev;
    logic [FC_W-1:0]  frame_cnt;
    logic             cursor_on;
    logic             s1_cursor_cell;

    // Cursor follows the last accepted host write; blink phase counts vsync rising edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_col    <= '0;
            cur_row    <= '0;
            vsync_prev <= 1'b0;
            frame_cnt  <= '0;
            cursor_on  <= 1'b0;
        end else begin
            if (host_wr_ok) begin
                cur_col <= wr_col;
                cur_row <= wr_row;
            end
            if (p_tick) begin
                vsync_prev <= vsync_in;
                if (vsync_in && !vsync_prev) begin
                    if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
                        frame_cnt <= '0;
                        cursor_on <= !cursor_on;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // Stage 1 flag: current pixel lies in the cursor cell.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_cursor_cell <= 1'b0;
        end else if (p_tick) begin
            s1_cursor_cell <= (pixel_x[9:3] == cur_col) && (pixel_y[8:4] == cur_row);
        end
    end

    assign cursor_pix = cursor_on && s1_cursor_cell && (s1_gy >= 4'd14);
`else
    assign cursor_pix = 1'b0;
`endif

    // Stage 2: colour the pixel and forward sync so all three leave together.
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb   <= '0;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else if (p_tick) begin
            hsync <= s1_hsync;
            vsync <= s1_vsync;
            if (!s1_video_on || state != ST_RUN) begin
                rgb <= '0;
            end else if (glyph_bit || cursor_pix) begin
                rgb <= FG_COLOR;
            end else begin
                rgb <= BG_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_vga_text_pixel_gen.sv
// Self-checking bench for vga_text_pixel_gen. A screen-level model (array of
// cell codes, glyph rule for dash/blank) predicts every pixel two p_ticks later.
// Build with +define+CURSOR_BLINK_EN to also exercise the blinking cursor.
module tb_vga_text_pixel_gen;

    localparam logic [2:0] FG = 3'b010;
    localparam logic [2:0] BG = 3'b000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       p_tick = 1'b0;
    logic       video_on = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [9:0] pixel_x = '0;
    logic [9:0] pixel_y = '0;
    logic       wr_en = 1'b0;
    logic [6:0] wr_col = '0;
    logic [4:0] wr_row = '0;
    logic [3:0] wr_code = '0;
    logic       busy;
    logic       hsync;
    logic       vsync;
    logic [2:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;

    // Screen model: one code per visible cell.
    logic [3:0] model [0:29][0:79];

    always #5 clk = ~clk;

    vga_text_pixel_gen dut (
        .clk      (clk),
        .reset    (reset),
        .p_tick   (p_tick),
        .video_on (video_on),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .wr_en    (wr_en),
        .wr_col   (wr_col),
        .wr_row   (wr_row),
        .wr_code  (wr_code),
        .busy     (busy),
        .hsync    (hsync),
        .vsync    (vsync),
        .rgb      (rgb)
    );

    function automatic logic [2:0] model_rgb(input int x, input int y, input logic vo);
        logic [3:0] code;
        int gy;
        if (!vo) return 3'b000;
        code = model[y / 16][x / 8];
        gy   = y % 16;
        if (code == 4'd14 && (gy == 7 || gy == 8)) return FG;
        return BG;
    endfunction

    task automatic model_blank();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                model[r][c] = 4'd15;
    endtask

    task automatic do_tick(input int x, input int y, input logic vo, input logic hs, input logic vs);
        @(negedge clk);
        pixel_x  = x[9:0];
        pixel_y  = y[9:0];
        video_on = vo;
        hsync_in = hs;
        vsync_in = vs;
        p_tick   = 1'b1;
        @(negedge clk);
        p_tick   = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input logic vo, output logic [2:0] r);
        do_tick(x, y, vo, 1'b0, 1'b0);
        do_tick(x, y, vo, 1'b0, 1'b0);
        r = rgb;
    endtask

    task automatic do_write(input int col, input int row, input logic [3:0] code);
        @(negedge clk);
        wr_col  = col[6:0];
        wr_row  = row[4:0];
        wr_code = code;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        if (col < 80 && row < 30) model[row][col] = code;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts clocks until busy falls (bounded), compares with the 4096-clock sweep.
    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== 4096) begin
            n_fail++;
            $display("FAIL %s clear_length: got %0d clks, expected 4096", tag, n);
        end
        model_blank();
    endtask

    task automatic test_reset();
        int n = 0;
        logic [2:0] r;
        @(negedge clk);
        reset = 1'b1;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        p_tick = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        p_tick = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        n_checks += 4;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b expected 1", busy); end
        if (rgb !== 3'b000) begin n_fail++; $display("FAIL reset_rgb: got %b expected 000", rgb); end
        if (hsync !== 1'b0) begin n_fail++; $display("FAIL reset_hsync: got %b expected 0", hsync); end
        if (vsync !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b expected 0", vsync); end

        // Walk through the clear, poking a write and visible pixels into it.
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
            wr_en    = (n == 10);
            wr_col   = 7'd0;
            wr_row   = 5'd0;
            wr_code  = 4'd14;
            p_tick   = (n >= 20 && n < 23);
            video_on = 1'b1;
            pixel_x  = 10'd0;
            pixel_y  = 10'd7;
            if (n == 24) begin
                n_checks++;
                if (rgb !== 3'b000) begin
                    n_fail++;
                    $display("FAIL clear_rgb_forced_off: got %b expected 000", rgb);
                end
            end
        end
        wr_en = 1'b0;
        p_tick = 1'b0;
        n_checks++;
        if (n !== 4096) begin
            n_fail++;
            $display("FAIL clear_length: got %0d clks, expected 4096", n);
        end
        model_blank();

        probe(0, 7, 1'b1, r);
        n_checks++;
        if (r !== BG) begin
            n_fail++;
            $display("FAIL write_during_clear_ignored: got %b expected %b", r, BG);
        end
    endtask

    task automatic test_mid_reset();
        logic [2:0] r;
        do_write(3, 3, 4'd14);
        probe(24, 55, 1'b1, r);
        n_checks++;
        if (r !== model_rgb(24, 55, 1'b1)) begin
            n_fail++;
            $display("FAIL pre_reset_write: got %b expected %b", r, model_rgb(24, 55, 1'b1));
        end
        pulse_reset();
        repeat (100) @(negedge clk);
        pulse_reset();
        wait_clear("mid_reset");
        probe(24, 55, 1'b1, r);
        n_checks++;
        if (r !== BG) begin
            n_fail++;
            $display("FAIL clear_erases_cell: got %b expected %b", r, BG);
        end
    endtask

    task automatic test_glyph();
        logic [2:0] r;
        do_write(2, 1, 4'd14);
        for (int x = 16; x < 24; x++) begin
            probe(x, 23, 1'b1, r);
            n_checks++;
            if (r !== FG) begin
                n_fail++;
                $display("FAIL dash_row x=%0d y=23: got %b expected %b", x, r, FG);
            end
        end
        probe(16, 22, 1'b1, r);
        n_checks++;
        if (r !== BG) begin
            n_fail++;
            $display("FAIL dash_gap x=16 y=22: got %b expected %b", r, BG);
        end
    endtask

    task automatic test_latency();
        int xs[40];
        int ys[40];
        logic vos[40];
        logic hss[40];
        logic vss[40];
        int rises = 0;
        logic prev_vs = 1'b0;
        logic [2:0] held_rgb;
        logic held_hs;
        logic held_vs;

        do_tick(0, 0, 1'b0, 1'b0, 1'b0);
        do_tick(0, 0, 1'b0, 1'b0, 1'b0);
        do_tick(20, 23, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (hsync !== 1'b0) begin
            n_fail++;
            $display("FAIL hsync_early: got %b expected 0 after first tick", hsync);
        end
        do_tick(0, 0, 1'b0, 1'b1, 1'b0);
        n_checks += 2;
        if (hsync !== 1'b1) begin
            n_fail++;
            $display("FAIL hsync_latency: got %b expected 1 after second tick", hsync);
        end
        if (rgb !== FG) begin
            n_fail++;
            $display("FAIL rgb_aligned_with_hsync: got %b expected %b", rgb, FG);
        end

        // p_tick held low: inputs move, outputs must not.
        held_rgb = rgb;
        held_hs  = hsync;
        held_vs  = vsync;
        @(negedge clk);
        pixel_x  = 10'd400;
        pixel_y  = 10'd300;
        video_on = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b1;
        repeat (6) @(negedge clk);
        vsync_in = 1'b0;
        n_checks += 3;
        if (rgb !== held_rgb) begin n_fail++; $display("FAIL hold_rgb: got %b expected %b", rgb, held_rgb); end
        if (hsync !== held_hs) begin n_fail++; $display("FAIL hold_hsync: got %b expected %b", hsync, held_hs); end
        if (vsync !== held_vs) begin n_fail++; $display("FAIL hold_vsync: got %b expected %b", vsync, held_vs); end

        // Random stream: each output reflects the input of the previous tick.
        for (int i = 0; i < 40; i++) begin
            xs[i]  = ($urandom % 2) ? 16 + int'($urandom_range(7)) : int'($urandom_range(639));
            ys[i]  = ($urandom % 2) ? 23 : int'($urandom_range(479));
            vos[i] = 1'($urandom % 2);
            hss[i] = 1'($urandom % 2);
            vss[i] = (rises < 10) ? 1'($urandom % 2) : 1'b0;
            if (vss[i] && !prev_vs) rises++;
            prev_vs = vss[i];
        end
        for (int i = 0; i < 40; i++) begin
            do_tick(xs[i], ys[i], vos[i], hss[i], vss[i]);
            if (i > 0) begin
                n_checks += 3;
                if (rgb !== model_rgb(xs[i-1], ys[i-1], vos[i-1])) begin
                    n_fail++;
                    $display("FAIL stream_rgb[%0d] x=%0d y=%0d: got %b expected %b", i,
                             xs[i-1], ys[i-1], rgb, model_rgb(xs[i-1], ys[i-1], vos[i-1]));
                end
                if (hsync !== hss[i-1]) begin
                    n_fail++;
                    $display("FAIL stream_hsync[%0d]: got %b expected %b", i, hsync, hss[i-1]);
                end
                if (vsync !== vss[i-1]) begin
                    n_fail++;
                    $display("FAIL stream_vsync[%0d]: got %b expected %b", i, vsync, vss[i-1]);
                end
            end
        end
        do_tick(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_video_off();
        logic [2:0] r;
        probe(16, 23, 1'b0, r);
        n_checks++;
        if (r !== 3'b000) begin
            n_fail++;
            $display("FAIL video_off_blank: got %b expected 000", r);
        end
    endtask

    task automatic test_bad_writes();
        logic [2:0] r;
        do_write(80, 29, 4'd14);
        do_write(79, 30, 4'd14);
        do_write(127, 31, 4'd14);
        for (int x = 632; x < 640; x += 7) begin
            probe(x, 471, 1'b1, r);
            n_checks++;
            if (r !== BG) begin
                n_fail++;
                $display("FAIL out_of_range_write x=%0d: got %b expected %b", x, r, BG);
            end
        end
        do_write(79, 29, 4'd14);
        probe(639, 472, 1'b1, r);
        n_checks++;
        if (r !== FG) begin
            n_fail++;
            $display("FAIL last_cell_write: got %b expected %b", r, FG);
        end
        do_write(79, 29, 4'd15);
    endtask

    task automatic test_collision();
        logic [2:0] r;
        logic [2:0] exp_old;
        exp_old = model_rgb(80, 87, 1'b1);
        @(negedge clk);
        pixel_x  = 10'd80;
        pixel_y  = 10'd87;
        video_on = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        p_tick   = 1'b1;
        wr_en    = 1'b1;
        wr_col   = 7'd10;
        wr_row   = 5'd5;
        wr_code  = 4'd14;
        @(negedge clk);
        p_tick   = 1'b0;
        wr_en    = 1'b0;
        model[5][10] = 4'd14;
        do_tick(0, 0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (rgb !== exp_old) begin
            n_fail++;
            $display("FAIL collision_old_code: got %b expected %b", rgb, exp_old);
        end
        probe(80, 87, 1'b1, r);
        n_checks++;
        if (r !== FG) begin
            n_fail++;
            $display("FAIL collision_new_code: got %b expected %b", r, FG);
        end
    endtask

    task automatic test_random();
        int col;
        int row;
        int x;
        int y;
        logic vo;
        logic [2:0] r;
        for (int i = 0; i < 40; i++) begin
            col = int'($urandom_range(84));
            row = int'($urandom_range(31));
            do_write(col, row, ($urandom % 2) ? 4'd14 : 4'd15);
            if (col < 80 && row < 30 && ($urandom % 3) != 0) begin
                x = col * 8 + int'($urandom_range(7));
                y = row * 16 + 7 + int'($urandom_range(1));
            end else begin
                x = int'($urandom_range(639));
                y = int'($urandom_range(479));
            end
            vo = ($urandom % 5) != 0;
            probe(x, y, vo, r);
            n_checks++;
            if (r !== model_rgb(x, y, vo)) begin
                n_fail++;
                $display("FAIL random[%0d] x=%0d y=%0d vo=%b: got %b expected %b",
                         i, x, y, vo, r, model_rgb(x, y, vo));
            end
        end
    endtask

`ifdef CURSOR_BLINK_EN
    task automatic test_cursor();
        logic [2:0] r;
        pulse_reset();
        wait_clear("cursor");
        do_write(5, 3, 4'd15);
        probe(40, 62, 1'b1, r);
        n_checks++;
        if (r !== BG) begin n_fail++; $display("FAIL cursor_initially_off: got %b expected %b", r, BG); end
        for (int i = 0; i < 30; i++) begin
            do_tick(0, 500, 1'b0, 1'b0, 1'b1);
            do_tick(0, 500, 1'b0, 1'b0, 1'b0);
        end
        for (int y = 62; y < 64; y++) begin
            for (int x = 40; x < 48; x++) begin
                probe(x, y, 1'b1, r);
                n_checks++;
                if (r !== FG) begin
                    n_fail++;
                    $display("FAIL cursor_on x=%0d y=%0d: got %b expected %b", x, y, r, FG);
                end
            end
        end
        probe(40, 61, 1'b1, r);
        n_checks++;
        if (r !== BG) begin n_fail++; $display("FAIL cursor_row61: got %b expected %b", r, BG); end
        probe(48, 62, 1'b1, r);
        n_checks++;
        if (r !== BG) begin n_fail++; $display("FAIL cursor_next_cell: got %b expected %b", r, BG); end
        probe(40, 62, 1'b0, r);
        n_checks++;
        if (r !== 3'b000) begin n_fail++; $display("FAIL cursor_video_off: got %b expected 000", r); end
        for (int i = 0; i < 30; i++) begin
            do_tick(0, 500, 1'b0, 1'b0, 1'b1);
            do_tick(0, 500, 1'b0, 1'b0, 1'b0);
        end
        probe(40, 62, 1'b1, r);
        n_checks++;
        if (r !== BG) begin n_fail++; $display("FAIL cursor_off_again: got %b expected %b", r, BG); end
    endtask
`endif

    initial begin
        model_blank();
        test_reset();
        test_glyph();
        test_latency();
        test_video_off();
        test_bad_writes();
        test_collision();
        test_random();
        test_mid_reset();
`ifdef CURSOR_BLINK_EN
        test_cursor();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
